// File: rtl/sram_pkg.sv
// Shared types and constants for the sram_ctrl block: FSM states, byte-lane
// count helper and the read-latency ceiling.
package sram_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam int RD_LAT_MAX = 4;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word storage with byte-masked writes and a registered read port.
// Per-byte even parity storage and checking are added when SRAM_CTRL_PARITY_EN is defined.
module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [byte_lanes(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]             rdata
`ifdef SRAM_CTRL_PARITY_EN
    ,
    output logic                          par_err
`endif
);

    localparam int NB    = byte_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // The read register only moves on a read, so it doubles as a hold stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

`ifdef SRAM_CTRL_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        p = '0;
        for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem_par[addr][i] <= ^wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_err <= 1'b0;
        else if (re) par_err <= |(byte_par(mem[addr]) ^ mem_par[addr]);
    end
`endif

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous single-port SRAM controller: clear sweep FSM, valid/ready request
// port and RD_LAT-deep read response pipeline. Optional parity via SRAM_CTRL_PARITY_EN.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter int                RD_LAT     = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [byte_lanes(DATA_W)-1:0] req_be,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    input  logic                          clear,
    output logic                          busy
`ifdef SRAM_CTRL_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int NB  = byte_lanes(DATA_W);
    localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              accept;
    logic              rd_accept;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic [NB-1:0]     arr_be;
    logic [LAT-1:0]    vld;
`ifdef SRAM_CTRL_PARITY_EN
    logic              arr_perr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) sweep_cnt <= sweep_cnt + 1'b1;
            else                sweep_cnt <= '0;
        end
    end

    // Handshake outputs come from state alone; clear only matters in IDLE.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (sweep_cnt == '1) next_state = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (clear) next_state = CLEAR;
            end
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;

    always_comb begin
        arr_we    = accept && req_we;
        arr_re    = rd_accept;
        arr_addr  = req_addr;
        arr_wdata = req_wdata;
        arr_be    = req_be;
        if (state == CLEAR) begin
            arr_we    = 1'b1;
            arr_addr  = sweep_cnt;
            arr_wdata = INIT_VALUE;
            arr_be    = '1;
        end
    end

    sram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (arr_we),
        .re     (arr_re),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .be     (arr_be),
        .rdata  (arr_rdata)
`ifdef SRAM_CTRL_PARITY_EN
        ,
        .par_err(arr_perr)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else begin
            vld[0] <= rd_accept;
            for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
        end
    end

    assign rsp_valid = vld[LAT-1];

    // Each data stage loads only when its item is valid, so the last stage holds between responses.
    if (LAT == 1) begin : g_direct
        assign rsp_rdata = arr_rdata;
`ifdef SRAM_CTRL_PARITY_EN
        assign parity_err = arr_perr;
`endif
    end else begin : g_pipe
        logic [DATA_W-1:0] pipe_d [LAT-1];
`ifdef SRAM_CTRL_PARITY_EN
        logic [LAT-2:0] pipe_e;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LAT-1; i++) pipe_d[i] <= '0;
`ifdef SRAM_CTRL_PARITY_EN
                pipe_e <= '0;
`endif
            end else begin
                if (vld[0]) pipe_d[0] <= arr_rdata;
                for (int i = 1; i < LAT-1; i++) begin
                    if (vld[i]) pipe_d[i] <= pipe_d[i-1];
                end
`ifdef SRAM_CTRL_PARITY_EN
                if (vld[0]) pipe_e[0] <= arr_perr;
                for (int i = 1; i < LAT-1; i++) begin
                    if (vld[i]) pipe_e[i] <= pipe_e[i-1];
                end
`endif
            end
        end

        assign rsp_rdata = pipe_d[LAT-2];
`ifdef SRAM_CTRL_PARITY_EN
        assign parity_err = pipe_e[LAT-2];
`endif
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised self-checking bench for sram_ctrl: two instances (RD_LAT 1 and 3)
// share one stimulus stream and are scored against a word-array reference model.
module tb_sram_ctrl;

    localparam int          DW    = 32;
    localparam int          AW    = 8;
    localparam int          DEPTH = 256;
    localparam logic [31:0] INIT  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        clear;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  busy;
    logic [31:0] rsp_rdata [2];
`ifdef SRAM_CTRL_PARITY_EN
    logic [1:0]  parity_err;
`endif

    logic [31:0] ref_mem [DEPTH];
    bit          corrupt [DEPTH];
    logic [31:0] exp_data [$];
    int          exp_edge [$];
    bit          exp_perr [$];
    int          idx [2];
    int          run_len [2];
    int          done_len [2];
    logic [31:0] last_rsp [2];
    int          edges;
    int          ready_viol;
    int          checks;
    int          errors;

    sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_VALUE(INIT)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .clear(clear), .busy(busy[0])
`ifdef SRAM_CTRL_PARITY_EN
        , .parity_err(parity_err[0])
`endif
    );

    sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .INIT_VALUE(INIT)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .clear(clear), .busy(busy[1])
`ifdef SRAM_CTRL_PARITY_EN
        , .parity_err(parity_err[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelInit();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = INIT;
            corrupt[i] = 1'b0;
        end
    endtask

    // One request cycle: drive, sample ready mid-cycle, and update the model at the acceptance edge.
    task automatic applyStimulus(input bit v, input bit we, input logic [7:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input bit clr);
        bit rdy;
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        clear     = clr;
        @(negedge clk);
        rdy = req_ready[0];
        @(posedge clk);
        #1;
        if (rdy && v) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) ref_mem[addr][8*i +: 8] = wdata[8*i +: 8];
                end
                if (be[0]) corrupt[addr] = 1'b0;
            end else begin
                exp_data.push_back(ref_mem[addr]);
                exp_edge.push_back(edges);
                exp_perr.push_back(corrupt[addr]);
            end
        end
        if (rdy && clr) modelInit();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic assertReset(input string tag, input int n);
        reset     = 1'b1;
        req_valid = 1'b0;
        clear     = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idx[d]      = exp_data.size();
            done_len[d] = 0;
        end
        modelInit();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput({tag, "_ready"}, 64'(req_ready[d]), 64'd0);
            checkOutput({tag, "_busy"}, 64'(busy[d]), 64'd1);
            checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'd0);
            checkOutput({tag, "_rsp_rdata"}, 64'(rsp_rdata[d]), 64'd0);
`ifdef SRAM_CTRL_PARITY_EN
            checkOutput({tag, "_parity_err"}, 64'(parity_err[d]), 64'd0);
`endif
        end
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitSweep(input string tag);
        for (int i = 0; i < 600 && busy != 2'b00; i++) @(negedge clk);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput({tag, "_busy_end"}, 64'(busy[d]), 64'd0);
            checkOutput({tag, "_len"}, 64'(done_len[d]), 64'd256);
        end
    endtask

    task automatic checkLast(input string tag, input logic [31:0] expected);
        for (int d = 0; d < 2; d++) checkOutput(tag, 64'(last_rsp[d]), 64'(expected));
    endtask

    // Response scoreboard, sweep-length measurement and ready/busy exclusivity.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                run_len[d] = 0;
            end else begin
                if (busy[d] == req_ready[d]) ready_viol++;
                if (busy[d]) run_len[d]++;
                else if (run_len[d] != 0) begin
                    done_len[d] = run_len[d];
                    run_len[d]  = 0;
                end
                if (rsp_valid[d]) begin
                    if (idx[d] < exp_data.size()) begin
                        checkOutput($sformatf("rsp_data[%0d]", d), 64'(rsp_rdata[d]), 64'(exp_data[idx[d]]));
                        checkOutput($sformatf("rsp_lat[%0d]", d), 64'(edges), 64'(exp_edge[idx[d]] + lat_of(d) - 1));
`ifdef SRAM_CTRL_PARITY_EN
                        checkOutput($sformatf("parity_err[%0d]", d), 64'(parity_err[d]), 64'(exp_perr[idx[d]]));
`endif
                        last_rsp[d] = rsp_rdata[d];
                        idx[d]++;
                    end else begin
                        checkOutput($sformatf("rsp_unexpected[%0d]", d), 64'(rsp_valid[d]), 64'd0);
                    end
                end
                while (idx[d] < exp_data.size() && exp_edge[idx[d]] + lat_of(d) - 1 < edges) begin
                    checkOutput($sformatf("rsp_missing[%0d]", d), 64'(edges), 64'(exp_edge[idx[d]] + lat_of(d) - 1));
                    idx[d]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        ready_viol = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        clear      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idx[d]      = 0;
            run_len[d]  = 0;
            done_len[d] = 0;
            last_rsp[d] = '0;
        end

        $display("[TB] reset and initial sweep");
        assertReset("por", 3);
        waitSweep("por_sweep");
        applyStimulus(1'b1, 1'b0, 8'd0,   32'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd127, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd255, 32'h0, 4'h0, 1'b0);
        idle(5);
        checkLast("init_read_255", 32'h0000_0000);

        $display("[TB] byte-enable merge");
        applyStimulus(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h10, 32'h0000_00AA, 4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
        idle(5);
        checkLast("be_merge_10", 32'hDEAD_BEAA);

        $display("[TB] back-to-back stream");
        for (int a = 0; a < 8; a++) applyStimulus(1'b1, 1'b1, 8'(a), 32'(a) * 32'h1111_1111, 4'hF, 1'b0);
        for (int a = 0; a < 8; a++) applyStimulus(1'b1, 1'b0, 8'(a), 32'h0, 4'h0, 1'b0);
        idle(5);
        checkLast("stream_last", 32'h7777_7777);

`ifdef SRAM_CTRL_PARITY_EN
        $display("[TB] parity flip at addr 3");
        dut_a.u_array.mem_par[3][0] = ~dut_a.u_array.mem_par[3][0];
        dut_b.u_array.mem_par[3][0] = ~dut_b.u_array.mem_par[3][0];
        corrupt[3] = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd3, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd4, 32'h0, 4'h0, 1'b0);
        idle(5);
`endif

        $display("[TB] randomised traffic");
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                          $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end
        idle(6);

        $display("[TB] clear with concurrent read, clear held");
        applyStimulus(1'b1, 1'b1, 8'd5, 32'h1234_5678, 4'hF, 1'b0);
        for (int d = 0; d < 2; d++) done_len[d] = 0;
        applyStimulus(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, 1'b1);
        repeat (200) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
        clear = 1'b0;
        waitSweep("clear_sweep");
        checkLast("clear_pre_read", 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, 1'b0);
        idle(5);
        checkLast("clear_post_read", INIT);

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
        idle(100);
        assertReset("mid_sweep_rst", 3);
        waitSweep("mid_sweep");

        $display("[TB] reset with reads in flight");
        applyStimulus(1'b1, 1'b1, 8'd9, 32'hCAFE_F00D, 4'hF, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd9, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd9, 32'h0, 4'h0, 1'b0);
        assertReset("inflight_rst", 2);
        waitSweep("inflight_sweep");
        applyStimulus(1'b1, 1'b0, 8'd9, 32'h0, 4'h0, 1'b0);
        idle(5);
        checkLast("inflight_post_read", INIT);

        checkOutput("ready_busy_excl", 64'(ready_viol), 64'd0);
        for (int d = 0; d < 2; d++) checkOutput("all_rsp_seen", 64'(idx[d]), 64'(exp_data.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised, synchronous single-port SRAM block with a valid/ready request port and a pipelined read-response port.
- Next-generation replacement for the team's asynchronous we/oe tri-state memory model.
- Adds configurable width and depth, byte-enable writes, configurable read latency, and a hardware clear sweep.
- Sits between game-logic/datapath masters (board state, shot table) and storage; one master per instance.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid; legal range 1..4
INIT_VALUE, 0, word written to every location during a clear sweep

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_be  input  DATA_W/8  byte enables for writes; bit i covers data bits 8i+7..8i
rsp_valid  output  1  one-cycle pulse: rsp_rdata is valid
rsp_rdata  output  DATA_W  read data
clear  input  1  pulse: start a clear sweep
busy  output  1  high while a clear sweep is running

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1.
  - The read pipeline is flushed; the sweep counter is set to 0; state is set to CLEAR.
  - Array contents are not reset directly; the sweep initialises them.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Writes INIT_VALUE to address sweep_cnt every cycle, all bytes enabled, then increments sweep_cnt.
  - Moves to IDLE on the cycle that writes DEPTH-1; takes exactly DEPTH cycles after reset release.
  - busy=1 and req_ready=0 throughout.
  - clear asserted during CLEAR is ignored; the sweep does not restart.
- IDLE:
  - req_ready=1 and busy=0.
  - req_ready depends only on state, never on req_valid or clear (no combinational path).
- Accept rule: a request is accepted on a rising edge where req_valid && req_ready. Sustained throughput is one request per cycle.
- Write acceptance:
  - Bytes with req_be[i]=1 are updated at the acceptance edge; other bytes are unchanged.
  - req_be=0 is a legal no-op write.
  - A write produces no response.
- Read acceptance:
  - The addressed word is captured at the acceptance edge.
  - rsp_valid pulses for exactly one cycle, RD_LAT cycles later; rsp_rdata is held until the next response.
  - Responses return in request order; no backpressure on the response port.
- Read-after-write: a read accepted any cycle after a write to the same address returns the new data, including a back-to-back read on the next cycle.
- clear in IDLE:
  - Enters CLEAR on the next edge with sweep_cnt=0.
  - A request accepted in the same cycle as clear is still executed before the sweep.
  - Reads already in the pipeline complete and return pre-clear data.
- Reset during CLEAR or with reads in flight: the pipeline is dropped (no rsp_valid), and the sweep restarts from address 0 after reset release.
- Address wrap: not applicable; every ADDR_W value is a valid location.

Optional Feature:
- Macro: SRAM_CTRL_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte.
  - Parity is written for enabled bytes on writes, and for all bytes during a sweep.
  - Parity is checked on reads; the extra output parity_err (1 bit) is aligned with rsp_valid and is high if any byte of the returned word mismatches.
  - parity_err resets to 0.
- When undefined: no parity storage, no parity_err port, and no extra logic.

Decomposition:
- Shared package sram_pkg holds:
  - typedef of the state enum (CLEAR, IDLE)
  - localparam function for DATA_W/8 byte-lane count
  - localparam RD_LAT_MAX=4
- Sub-module sram_array holds:
  - storage array
  - byte-masked synchronous write
  - registered read port
  - parity bits when the macro is set
- sram_ctrl holds:
  - FSM and sweep counter
  - accept logic
  - RD_LAT-deep valid/data shift pipeline

Test Plan:
- Reset released -> busy=1 and req_ready=0 for exactly 256 cycles (ADDR_W=8); then reads of addresses 0, 127, 255 return 0x00000000.
- Write 0xDEADBEEF at addr 0x10 with be=4'b1111, then write 0x000000AA with be=4'b0001; read addr 0x10 -> 0xDEADBEAA, with rsp_valid RD_LAT cycles after acceptance (checked for RD_LAT=1 and RD_LAT=3).
- Back-to-back stream: writes to addrs 0..7 with data addr*0x11111111, then 8 consecutive reads -> 8 consecutive rsp_valid pulses in order, zero bubbles.
- Clear test:
  - Setup: addr 5 holds 0x12345678; issue clear together with a read of addr 5.
  - Expected: the response is 0x12345678; busy then stays high for 256 cycles; a subsequent read of addr 5 returns INIT_VALUE.
  - Check: clear held high during the sweep does not extend it.
- Reset asserted mid-sweep (cycle 100) and with 2 reads in flight -> no rsp_valid emitted; the sweep restarts and completes 256 cycles after release.
- With SRAM_CTRL_PARITY_EN defined: the bench forces a stored parity bit flip at addr 3; reading addr 3 -> parity_err=1 aligned with rsp_valid; reading addr 4 -> parity_err=0.
